mem_dma: RTL and testbench
==========================

MEM_DMA -- requirements
Module: mem_dma

Interface
REQ-001 Parameters: none; data and address widths are fixed at 16 bits and the address space is 65536 words.
REQ-002 The block SHALL have one clock; reset SHALL be synchronous and active-high.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 reset  in  1  synchronous active-high reset.
REQ-005 start  in  1  request a transfer; sampled only in IDLE.
REQ-006 mode  in  1  0 = copy src->dst, 1 = fill dst with fill_value.
REQ-007 src_addr  in  16  first source word address (copy mode only).
REQ-008 dst_addr  in  16  first destination word address.
REQ-009 length  in  16  word count; 0 = no transfer.
REQ-010 fill_value  in  16  fill pattern (fill mode only).
REQ-011 busy  out  1  high while the transfer is in progress.
REQ-012 done  out  1  one-cycle completion pulse.
REQ-013 mem_write  out  1  memory write enable.
REQ-014 mem_write_address  out  16  memory write address.
REQ-015 mem_write_data  out  16  memory write data.
REQ-016 mem_read_address  out  16  memory read address.
REQ-017 mem_read_data  in  16  memory read data, combinational from mem_read_address in the same cycle.

Function
REQ-018 The FSM SHALL have three states: IDLE, XFER and DONE.
REQ-019 IDLE + start=1: latch mode, src_addr, dst_addr, length and fill_value; go to XFER if length!=0, otherwise go to DONE.
REQ-020 XFER SHALL issue exactly one write per cycle for the latched length cycles, then go to DONE.
REQ-021 DONE SHALL last one cycle with done=1, then go to IDLE.
REQ-022 busy SHALL be 1 only in XFER; done SHALL be 1 only in DONE.
REQ-023 start SHALL be ignored outside IDLE, and input changes after the latch SHALL have no effect.
REQ-024 Latency: start high at edge t gives writes on cycles t+1..t+length and done on cycle t+length+1.
REQ-025 In XFER, offset k SHALL drive mem_read_address = src+k and mem_write_address = dst+k, with mem_write=1.
REQ-026 All address arithmetic SHALL be modulo 2^16, so 0xFFFF+1 wraps to 0x0000.
REQ-027 Copy mode: mem_write_data SHALL equal mem_read_data in the same cycle.
REQ-028 Fill mode: mem_write_data SHALL equal the latched fill_value, and mem_read_address SHALL be 0.
REQ-029 Direction SHALL be backward (k = length-1 down to 0) when mode=0, d=(dst-src) mod 2^16 satisfies 0<d<length; otherwise forward (k = 0 up to length-1).
REQ-030 The result SHALL equal a non-overlapping memmove in both directions.
REQ-031 Outside XFER, mem_write SHALL be 0 and mem_write_address, mem_write_data and mem_read_address SHALL be 0.
REQ-032 The word counter SHALL be 16 bits; length=0xFFFF gives 65535 writes, and a full 65536-word transfer is not supported.
REQ-033 dst==src in copy mode SHALL run forward and rewrite the same values.

Reset
REQ-034 reset=1 at any edge SHALL force IDLE and clear the latched parameters and counter.
REQ-035 Reset SHALL drive busy=0, done=0, mem_write=0, and all address and data outputs to 0 in the following cycle.
REQ-036 Reset mid-XFER SHALL abort the transfer with no further writes and no done pulse; words already written remain.
REQ-037 reset SHALL have priority over start in the same cycle.

Verification
REQ-038 Copy: mem[0x0100..0x0103]={1,2,3,4}, start with mode=0, src=0x0100, dst=0x0200, len=4 -> 4 writes on cycles t+1..t+4, mem[0x0200..0x0203]={1,2,3,4}, done at t+5.
REQ-039 Overlap: mem[0x10..0x14]={A,B,C,D,E}, copy src=0x10, dst=0x12, len=3 -> backward writes at 0x14,0x13,0x12, result mem[0x12..0x14]={A,B,C}.
REQ-040 Fill with wrap: mode=1, dst=0xFFFE, len=4, fill=0xBEEF -> writes at 0xFFFE,0xFFFF,0x0000,0x0001, all 0xBEEF, with mem_read_address=0.
REQ-041 Zero length: start with len=0 -> no mem_write, busy stays 0, done at t+1.
REQ-042 Abort: reset asserted at the 3rd write of a len=8 copy -> exactly 2 completed writes, all outputs 0 next cycle, no done.
REQ-043 Ignored start: start pulsed during XFER and during DONE -> no new latch and no extra writes; the next start in IDLE is accepted normally.

Source files
------------

// File: rtl/mem_dma_if.sv
// Groups the mem_dma command, status and memory-port signals into one bundle.
// master is the DMA engine side; slave is the requester/memory side.
interface mem_dma_if;
    logic        start;
    logic        mode;
    logic [15:0] src_addr;
    logic [15:0] dst_addr;
    logic [15:0] length;
    logic [15:0] fill_value;
    logic        busy;
    logic        done;
    logic        mem_write;
    logic [15:0] mem_write_address;
    logic [15:0] mem_write_data;
    logic [15:0] mem_read_address;
    logic [15:0] mem_read_data;

    modport master (
        input  start, mode, src_addr, dst_addr, length, fill_value, mem_read_data,
        output busy, done, mem_write, mem_write_address, mem_write_data, mem_read_address
    );

    modport slave (
        output start, mode, src_addr, dst_addr, length, fill_value, mem_read_data,
        input  busy, done, mem_write, mem_write_address, mem_write_data, mem_read_address
    );
endinterface

// File: rtl/mem_dma.sv
// Word copy/fill DMA engine with memmove-safe direction choice, one write per cycle.
// Latency: start at edge t -> writes on cycles t+1..t+length, done on t+length+1.
// Backpressure: none; memory is assumed to accept a write and return read data every cycle.
module mem_dma (
    input  logic          clk,
    input  logic          reset,
    mem_dma_if.master     bus
);
    typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

    state_t      state, state_nxt;
    logic        mode_q, bwd_q;
    logic [15:0] src_q, dst_q, len_q, fill_q, cnt_q;
    logic [15:0] diff, offset;
    logic        last, latch, step;

    logic        busy_c, done_c, wr_c;
    logic [15:0] wr_addr_c, wr_data_c, rd_addr_c;

    // Copy runs backward only when the destination starts inside the source window.
    assign diff   = bus.dst_addr - bus.src_addr;
    assign offset = bwd_q ? (len_q - 16'd1 - cnt_q) : cnt_q;
    assign last   = (cnt_q == (len_q - 16'd1));

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        latch     = 1'b0;
        step      = 1'b0;
        busy_c    = 1'b0;
        done_c    = 1'b0;
        wr_c      = 1'b0;
        wr_addr_c = 16'd0;
        wr_data_c = 16'd0;
        rd_addr_c = 16'd0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    latch     = 1'b1;
                    state_nxt = (bus.length != 16'd0) ? XFER : DONE;
                end
            end
            XFER: begin
                busy_c    = 1'b1;
                wr_c      = 1'b1;
                step      = 1'b1;
                wr_addr_c = dst_q + offset;
                rd_addr_c = mode_q ? 16'd0 : (src_q + offset);
                wr_data_c = mode_q ? fill_q : bus.mem_read_data;
                if (last) state_nxt = DONE;
            end
            DONE: begin
                done_c    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q <= 1'b0;
            bwd_q  <= 1'b0;
            src_q  <= 16'd0;
            dst_q  <= 16'd0;
            len_q  <= 16'd0;
            fill_q <= 16'd0;
            cnt_q  <= 16'd0;
        end else if (latch) begin
            mode_q <= bus.mode;
            bwd_q  <= !bus.mode && (diff != 16'd0) && (diff < bus.length);
            src_q  <= bus.src_addr;
            dst_q  <= bus.dst_addr;
            len_q  <= bus.length;
            fill_q <= bus.fill_value;
            cnt_q  <= 16'd0;
        end else if (step) begin
            cnt_q  <= cnt_q + 16'd1;
        end
    end

    assign bus.busy              = busy_c;
    assign bus.done              = done_c;
    assign bus.mem_write         = wr_c;
    assign bus.mem_write_address = wr_addr_c;
    assign bus.mem_write_data    = wr_data_c;
    assign bus.mem_read_address  = rd_addr_c;
endmodule

// File: tb/tb_mem_dma.sv
// Directed bench for mem_dma with a write scoreboard and a behavioural word memory.
module tb_mem_dma;
    logic clk;
    logic reset;
    mem_dma_if bus();

    mem_dma dut (.clk(clk), .reset(reset), .bus(bus));

    logic [15:0] mem [0:65535];
    assign bus.mem_read_data = mem[bus.mem_read_address];
    always @(posedge clk) if (bus.mem_write === 1'b1) mem[bus.mem_write_address] <= bus.mem_write_data;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] wa;
        logic [15:0] wd;
        logic [15:0] ra;
    } wr_t;
    wr_t exp_q[$];

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic push(input logic [15:0] wa, input logic [15:0] wd, input logic [15:0] ra);
        wr_t e;
        e.wa = wa; e.wd = wd; e.ra = ra;
        exp_q.push_back(e);
    endtask

    // Every clock advance goes through here so any write the DUT issues is scored.
    task automatic step();
        wr_t e;
        @(posedge clk);
        #1;
        if (bus.mem_write !== 1'b0) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", 16'(bus.mem_write), 16'd0);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", bus.mem_write_address, e.wa);
                chk("wr_data", bus.mem_write_data, e.wd);
                chk("rd_addr", bus.mem_read_address, e.ra);
            end
        end
    endtask

    task automatic setup(input logic m, input logic [15:0] s, input logic [15:0] d,
                         input logic [15:0] n, input logic [15:0] f);
        bus.start = 1'b1; bus.mode = m; bus.src_addr = s;
        bus.dst_addr = d; bus.length = n; bus.fill_value = f;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"}, 16'(bus.busy), 16'd0);
        chk({tag, "_done"}, 16'(bus.done), 16'd0);
        chk({tag, "_mem_write"}, 16'(bus.mem_write), 16'd0);
        chk({tag, "_wr_addr"}, bus.mem_write_address, 16'd0);
        chk({tag, "_wr_data"}, bus.mem_write_data, 16'd0);
        chk({tag, "_rd_addr"}, bus.mem_read_address, 16'd0);
    endtask

    // Caller has already applied start; checks n write cycles then the done pulse.
    task automatic run(input string tag, input int n);
        step();
        bus.start = 1'b0;
        for (int i = 0; i < n; i++) begin
            chk({tag, "_busy"}, 16'(bus.busy), 16'd1);
            chk({tag, "_mem_write"}, 16'(bus.mem_write), 16'd1);
            chk({tag, "_done_early"}, 16'(bus.done), 16'd0);
            step();
        end
        chk({tag, "_done"}, 16'(bus.done), 16'd1);
        chk({tag, "_busy_in_done"}, 16'(bus.busy), 16'd0);
        chk({tag, "_wr_in_done"}, 16'(bus.mem_write), 16'd0);
        step();
        chk_idle({tag, "_after"});
        chk({tag, "_sb_empty"}, 16'(exp_q.size()), 16'd0);
    endtask

    initial begin
        reset = 1'b1;
        bus.start = 1'b0; bus.mode = 1'b0; bus.src_addr = 16'd0;
        bus.dst_addr = 16'd0; bus.length = 16'd0; bus.fill_value = 16'd0;
        step();
        step();
        chk_idle("reset");
        reset = 1'b0;
        step();
        chk_idle("idle");

        // Plain forward copy
        for (int i = 0; i < 4; i++) mem[16'h0100 + 16'(i)] = 16'(i + 1);
        for (int i = 0; i < 4; i++) push(16'h0200 + 16'(i), 16'(i + 1), 16'h0100 + 16'(i));
        setup(1'b0, 16'h0100, 16'h0200, 16'd4, 16'h0000);
        run("copy", 4);
        for (int i = 0; i < 4; i++) chk("copy_mem", mem[16'h0200 + 16'(i)], 16'(i + 1));

        // Overlapping copy must go backward
        for (int i = 0; i < 5; i++) mem[16'h0010 + 16'(i)] = 16'h000A + 16'(i);
        push(16'h0014, 16'h000C, 16'h0012);
        push(16'h0013, 16'h000B, 16'h0011);
        push(16'h0012, 16'h000A, 16'h0010);
        setup(1'b0, 16'h0010, 16'h0012, 16'd3, 16'h0000);
        run("overlap", 3);
        chk("overlap_mem10", mem[16'h0010], 16'h000A);
        chk("overlap_mem11", mem[16'h0011], 16'h000B);
        chk("overlap_mem12", mem[16'h0012], 16'h000A);
        chk("overlap_mem13", mem[16'h0013], 16'h000B);
        chk("overlap_mem14", mem[16'h0014], 16'h000C);

        // d == length is not an overlap hazard: forward
        for (int i = 0; i < 3; i++) mem[16'h0020 + 16'(i)] = 16'h0070 + 16'(i);
        for (int i = 0; i < 3; i++) push(16'h0023 + 16'(i), 16'h0070 + 16'(i), 16'h0020 + 16'(i));
        setup(1'b0, 16'h0020, 16'h0023, 16'd3, 16'h0000);
        run("d_eq_len", 3);

        // src == dst: forward rewrite of the same words
        mem[16'h0900] = 16'h1111; mem[16'h0901] = 16'h2222;
        push(16'h0900, 16'h1111, 16'h0900);
        push(16'h0901, 16'h2222, 16'h0901);
        setup(1'b0, 16'h0900, 16'h0900, 16'd2, 16'h0000);
        run("same", 2);

        // Fill across the top of the address space
        push(16'hFFFE, 16'hBEEF, 16'h0000);
        push(16'hFFFF, 16'hBEEF, 16'h0000);
        push(16'h0000, 16'hBEEF, 16'h0000);
        push(16'h0001, 16'hBEEF, 16'h0000);
        setup(1'b1, 16'h1234, 16'hFFFE, 16'd4, 16'hBEEF);
        run("fill_wrap", 4);
        chk("fill_mem0", mem[16'h0000], 16'hBEEF);
        chk("fill_memffff", mem[16'hFFFF], 16'hBEEF);

        // Zero length goes straight to DONE
        setup(1'b0, 16'h0100, 16'h0300, 16'd0, 16'h0000);
        run("zero_len", 0);

        // Reset beats start in the same cycle
        setup(1'b0, 16'h0100, 16'h0500, 16'd2, 16'h0000);
        reset = 1'b1;
        step();
        reset = 1'b0; bus.start = 1'b0;
        chk_idle("rst_prio");
        step();
        chk_idle("rst_prio2");

        // Abort: reset sampled at the edge that would begin the third write
        for (int i = 0; i < 8; i++) mem[16'h0300 + 16'(i)] = 16'h0100 + 16'(i);
        for (int i = 0; i < 8; i++) mem[16'h0400 + 16'(i)] = 16'hDEAD;
        push(16'h0400, 16'h0100, 16'h0300);
        push(16'h0401, 16'h0101, 16'h0301);
        setup(1'b0, 16'h0300, 16'h0400, 16'd8, 16'h0000);
        step();
        bus.start = 1'b0;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk_idle("abort");
        for (int i = 0; i < 4; i++) begin
            step();
            chk_idle("abort_quiet");
        end
        chk("abort_sb_empty", 16'(exp_q.size()), 16'd0);
        chk("abort_mem0", mem[16'h0400], 16'h0100);
        chk("abort_mem1", mem[16'h0401], 16'h0101);
        chk("abort_mem2", mem[16'h0402], 16'hDEAD);

        // Start pulses during XFER and DONE are ignored, as are parameter changes
        for (int i = 0; i < 3; i++) mem[16'h0500 + 16'(i)] = 16'h0051 + 16'(i);
        for (int i = 0; i < 3; i++) push(16'h0600 + 16'(i), 16'h0051 + 16'(i), 16'h0500 + 16'(i));
        setup(1'b0, 16'h0500, 16'h0600, 16'd3, 16'h0000);
        step();
        bus.start = 1'b0;
        chk("ign_busy1", 16'(bus.busy), 16'd1);
        step();
        setup(1'b1, 16'h0000, 16'h0700, 16'd5, 16'hFFFF);
        step();
        bus.start = 1'b0;
        chk("ign_busy3", 16'(bus.busy), 16'd1);
        step();
        chk("ign_done", 16'(bus.done), 16'd1);
        setup(1'b1, 16'h0000, 16'h0780, 16'd6, 16'hAAAA);
        step();
        bus.start = 1'b0;
        chk_idle("ign_idle");
        step();
        chk_idle("ign_idle2");
        chk("ign_sb_empty", 16'(exp_q.size()), 16'd0);
        chk("ign_mem602", mem[16'h0602], 16'h0053);

        push(16'h0800, 16'h1234, 16'h0000);
        push(16'h0801, 16'h1234, 16'h0000);
        setup(1'b1, 16'h0000, 16'h0800, 16'd2, 16'h1234);
        run("after_ign", 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
